uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  asynchronous, active-low reset; one clock; rst=0 SHALL force reset state immediately, independent of clk.
REQ-004 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 data_out  output  8  last correctly received byte; feeds the collector's data_input.
REQ-006 data_ready  output  1  one-clk pulse when data_out is updated with a valid byte; feeds the collector's data_ready.
REQ-007 frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-008 busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer before any use; all timing below refers to the synchronized signal rx_s.
REQ-010 The block SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY under REQ-022).
REQ-011 IDLE: on rx_s=0, the block SHALL enter START with the bit counter cleared.
REQ-012 START: at count CLKS_PER_BIT/2-1 (integer division), rx_s=0 SHALL go to DATA; rx_s=1 SHALL be treated as a glitch and go to IDLE, with no output pulse.
REQ-013 DATA: each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, so sampling falls at mid-bit; the counter then wraps to 0; bits SHALL be shifted in LSB first.
REQ-014 After the 8th data bit, DATA SHALL go to STOP (or to PARITY when enabled).
REQ-015 STOP: the stop bit SHALL be sampled at mid-bit; if 1, data_out SHALL load the shift register and data_ready SHALL pulse high for exactly one clk in the same cycle; then IDLE.
REQ-016 STOP sampled 0: frame_err SHALL pulse one clk, data_out and data_ready SHALL stay unchanged, and the state SHALL go to WAIT_IDLE; WAIT_IDLE SHALL return to IDLE only when rx_s=1, so a break is never decoded as a new start.
REQ-017 data_ready SHALL never be high on two consecutive cycles; at least one low cycle SHALL separate pulses, so a downstream rising-edge detector sees every byte.
REQ-018 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never exceed CLKS_PER_BIT-1.
REQ-019 Back-to-back frames: a start edge seen in the cycle after STOP completes SHALL be accepted with no frame lost.

Reset
REQ-020 While rst=0: state=IDLE, counters=0, shift register=0, data_out=8'h00, data_ready=0, frame_err=0, busy=0, synchronizer flops=1 (line idle).
REQ-021 Reset asserted mid-frame SHALL abort the frame without any pulse; after release the block SHALL wait for a fresh high-to-low start edge.

Configuration
REQ-022 With macro UART_RX_PARITY_EN defined: the block SHALL add a PARITY state between DATA and STOP that samples one even-parity bit at mid-bit; the block SHALL add an output parity_err  output  1  that pulses one clk at STOP time on mismatch; on mismatch data_ready SHALL be suppressed and data_out SHALL be kept.
REQ-023 Without UART_RX_PARITY_EN: frames SHALL be 8N1, the PARITY state and the parity_err port SHALL not exist, and behaviour SHALL match REQ-009..REQ-019 exactly.

Verification (CLKS_PER_BIT=16)
REQ-024 Send 8'hA5 as 8N1 -> data_out=8'hA5, one data_ready pulse about 152 clks after the start edge, frame_err=0.
REQ-025 Send 40 back-to-back bytes 0x00..0x27 -> exactly 40 data_ready pulses, values in order, each pulse separated by at least 1 low cycle.
REQ-026 Hold rx low for 4 clks, then high -> no pulse on any output, busy returns to 0 within 12 clks.
REQ-027 Send 8'h3C with stop bit 0, then hold rx low for 100 clks -> one frame_err pulse, no data_ready, data_out unchanged, no decode until rx returns high.
REQ-028 Drive rst=0 for 3 clks during bit 4 of 8'hFF, then send 8'h12 -> no pulse for the aborted byte, data_out=8'h12 afterwards.
REQ-029 With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> parity_err pulse, no data_ready; resend with parity bit 1 -> data_out=8'h07.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial input and the byte-level outputs of uart_rx.
// Optional feature macro: UART_RX_PARITY_EN adds the parity_err signal.
// slave  : the receiver side (samples rx, drives the results)
// master : the side that drives the line and consumes received bytes
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport slave  (input  rx, output data_out, data_ready, frame_err, busy, parity_err);
  modport master (output rx, input  data_out, data_ready, frame_err, busy, parity_err);
`else
  modport slave  (input  rx, output data_out, data_ready, frame_err, busy);
  modport master (output rx, input  data_out, data_ready, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits, LSB first, 1 stop bit.
// Optional feature macro: UART_RX_PARITY_EN inserts one even-parity bit
// between the data bits and the stop bit and reports mismatches on parity_err.
// rst is asynchronous and active-low; all state moves on the rising clk edge.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4,
    PARITY    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;
`endif

  logic          rx_meta;
  logic          rx_s;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    data_q, data_next;
  logic          ready_q, ready_next;
  logic          ferr_q, ferr_next;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_bit_next;
  logic          perr_q, perr_next;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // State register plus counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      data_q  <= data_next;
      ready_q <= ready_next;
      ferr_q  <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_next;
      perr_q  <= perr_next;
`endif
    end
  end

  // Next-state and datapath logic; pulses default low so each lasts one clk
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    data_next    = data_q;
    ready_next   = 1'b0;
    ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit;
    perr_next    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_next     = '0;
          par_bit_next = rx_s;
          state_next   = STOP;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if ((^shift) ^ par_bit) begin
              perr_next = 1'b1;
            end else begin
              data_next  = shift;
              ready_next = 1'b1;
            end
`else
            data_next  = shift;
            ready_next = 1'b1;
`endif
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_ready = ready_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clks per bit.
// Optional feature macro: UART_RX_PARITY_EN (adds parity bits and parity test).
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   ready_cnt = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;
  int   consec_cnt = 0;
  logic prev_ready = 1'b0;
  logic [7:0] got_q[$];
  time  last_ready_t = 0;

  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Collect output pulses on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (bus_if.data_ready === 1'b1) begin
      ready_cnt++;
      got_q.push_back(bus_if.data_out);
      last_ready_t = $time;
      if (prev_ready === 1'b1) consec_cnt++;
    end
    prev_ready = bus_if.data_ready;
    if (bus_if.frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus_if.parity_err === 1'b1) perr_cnt++;
`endif
  end

  task automatic send_bit(input logic b);
    bus_if.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) bus_if.rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.rx = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus_if.data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h want=00", bus_if.data_out); end
    total++; if (bus_if.data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready got=%b want=0", bus_if.data_ready); end
    total++; if (bus_if.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", bus_if.frame_err); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
    bus_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", bus_if.busy); end
  endtask

  task automatic test_single_a5();
    int  r0, f0, lat, exp_lat;
    time t0;
    r0 = ready_cnt; f0 = ferr_cnt;
    t0 = $time;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    exp_lat = 155;
`ifdef UART_RX_PARITY_EN
    exp_lat = exp_lat + CPB;
`endif
    lat = int'((last_ready_t - t0) / 10);
    total++; if (ready_cnt - r0 !== 1) begin bad++; $display("FAIL a5_pulses got=%0d want=1", ready_cnt - r0); end
    total++; if (bus_if.data_out !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", bus_if.data_out); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d want=0", ferr_cnt - f0); end
    total++; if (lat < exp_lat - 5 || lat > exp_lat + 5) begin bad++; $display("FAIL a5_latency got=%0d want=%0d+-5", lat, exp_lat); end
  endtask

  task automatic test_back_to_back();
    int r0;
    logic [7:0] v;
    r0 = ready_cnt;
    got_q.delete();
    consec_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      v = 8'(i);
      send_frame(v, ^v, 1'b1);
    end
    repeat (10) @(negedge clk);
    total++; if (ready_cnt - r0 !== 40) begin bad++; $display("FAIL b2b_count got=%0d want=40", ready_cnt - r0); end
    total++; if (consec_cnt !== 0) begin bad++; $display("FAIL b2b_consecutive got=%0d want=0", consec_cnt); end
    for (int i = 0; i < 40; i++) begin
      v = 8'(i);
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL b2b_missing idx=%0d want=%h", i, v); end
      else if (got_q[i] !== v) begin bad++; $display("FAIL b2b_value idx=%0d got=%h want=%h", i, got_q[i], v); end
    end
  endtask

  task automatic test_glitch();
    int r0, f0, p0;
    logic [7:0] d0;
    r0 = ready_cnt; f0 = ferr_cnt; p0 = perr_cnt; d0 = bus_if.data_out;
    bus_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b want=1", bus_if.busy); end
    bus_if.rx = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_low got=%b want=0", bus_if.busy); end
    total++; if ((ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", (ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0)); end
    total++; if (bus_if.data_out !== d0) begin bad++; $display("FAIL glitch_data got=%h want=%h", bus_if.data_out, d0); end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    r0 = ready_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    bus_if.rx = 1'b0;
    repeat (100) @(negedge clk);
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", ferr_cnt - f0); end
    total++; if (ready_cnt - r0 !== 0) begin bad++; $display("FAIL ferr_ready got=%0d want=0", ready_cnt - r0); end
    total++; if (bus_if.data_out !== 8'h27) begin bad++; $display("FAIL ferr_data got=%h want=27", bus_if.data_out); end
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL ferr_break_busy got=%b want=1", bus_if.busy); end
    bus_if.rx = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL ferr_idle_busy got=%b want=0", bus_if.busy); end
    total++; if (ferr_cnt - f0 !== 1 || ready_cnt - r0 !== 0) begin bad++; $display("FAIL ferr_after_break ferr=%0d ready=%0d want=1,0", ferr_cnt - f0, ready_cnt - r0); end
    send_frame(8'h5A, ^8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (bus_if.data_out !== 8'h5A || ready_cnt - r0 !== 1) begin bad++; $display("FAIL ferr_recover data=%h pulses=%0d want=5a,1", bus_if.data_out, ready_cnt - r0); end
  endtask

  task automatic test_reset_abort();
    int r0, f0;
    r0 = ready_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_if.rx = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", bus_if.busy); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL abort_async_busy got=%b want=0", bus_if.busy); end
    total++; if (bus_if.data_out !== 8'h00) begin bad++; $display("FAIL abort_async_data got=%h want=00", bus_if.data_out); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b1);
    repeat (20) @(negedge clk);
    total++; if ((ready_cnt - r0) + (ferr_cnt - f0) !== 0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", (ready_cnt - r0) + (ferr_cnt - f0)); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", bus_if.busy); end
    send_frame(8'h12, ^8'h12, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (bus_if.data_out !== 8'h12) begin bad++; $display("FAIL abort_resend_data got=%h want=12", bus_if.data_out); end
    total++; if (ready_cnt - r0 !== 1) begin bad++; $display("FAIL abort_resend_pulses got=%0d want=1", ready_cnt - r0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int r0, p0;
    r0 = ready_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL parity_err_pulse got=%0d want=1", perr_cnt - p0); end
    total++; if (ready_cnt - r0 !== 0) begin bad++; $display("FAIL parity_ready_suppressed got=%0d want=0", ready_cnt - r0); end
    total++; if (bus_if.data_out !== 8'h12) begin bad++; $display("FAIL parity_data_kept got=%h want=12", bus_if.data_out); end
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (bus_if.data_out !== 8'h07 || ready_cnt - r0 !== 1) begin bad++; $display("FAIL parity_good data=%h pulses=%0d want=07,1", bus_if.data_out, ready_cnt - r0); end
    total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL parity_good_no_err got=%0d want=1", perr_cnt - p0); end
  endtask
`endif

  initial begin
    bus_if.rx = 1'b1;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
